// File: rtl/toy_intc.sv
`default_nettype none
// ============================================================================
// Module      : toy_intc
// Description : CPU-side interrupt controller for the toy I/O devices.
//               Collects sticky device interrupt levels, masks them,
//               arbitrates one winner, raises irq/irqId to the core and runs
//               the take / ack / EOI handshake with the serviced device.
// Ports       : clk      - system clock, rising edge
//               rst      - asynchronous active-high reset
//               intr     - device interrupt levels (bit i = device i)
//               ack      - registered one-cycle acknowledge to the device
//               maskWe   - enable-mask write strobe
//               maskIn   - new mask value (1 = enabled)
//               maskOut  - current mask
//               irq      - registered interrupt request to the CPU
//               irqId    - ID of the requesting / in-service source
//               take     - CPU accepts the interrupt (pulse)
//               eoi      - CPU end-of-interrupt (pulse)
//               busy     - high while in ACK or SERVICE
// Options     : TOY_INTC_RR_EN - round-robin arbitration starting after the
//               last taken source; fixed lowest-index priority otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module toy_intc #(
    parameter int N_DEV = 2,
    parameter int ID_W  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] intr,
    output logic [N_DEV-1:0] ack,
    input  logic             maskWe,
    input  logic [N_DEV-1:0] maskIn,
    output logic [N_DEV-1:0] maskOut,
    output logic             irq,
    output logic [ID_W-1:0]  irqId,
    input  logic             take,
    input  logic             eoi,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_ACK     = 2'd2,
        S_SERVICE = 2'd3
    } state_t;

    state_t            state_q;
    logic              irq_q;
    logic [ID_W-1:0]   irqId_q;
    logic [N_DEV-1:0]  ack_q;
    logic [N_DEV-1:0]  mask_q;

    logic [N_DEV-1:0]  pend;
    logic [ID_W-1:0]   winner;
    logic              pendSel;
    logic [N_DEV-1:0]  ackSel;

    assign pend = intr & mask_q;

`ifdef TOY_INTC_RR_EN
    logic [ID_W-1:0] lastId_q;

    // Scan offsets N_DEV down to 1 so the smallest offset past lastId wins.
    always_comb begin
        int idx;
        winner = '0;
        for (int k = N_DEV; k >= 1; k--) begin
            idx = (int'(lastId_q) + k) % N_DEV;
            for (int j = 0; j < N_DEV; j++) begin
                if ((j == idx) && pend[j]) begin
                    winner = ID_W'(j);
                end
            end
        end
    end
`else
    // Fixed priority: descending scan leaves the lowest set index.
    always_comb begin
        winner = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (pend[i]) begin
                winner = ID_W'(i);
            end
        end
    end
`endif

    // Pending level of the currently requested source, and its one-hot ack.
    always_comb begin
        pendSel = 1'b0;
        ackSel  = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (irqId_q == ID_W'(i)) begin
                pendSel   = pend[i];
                ackSel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            irq_q    <= 1'b0;
            irqId_q  <= '0;
            ack_q    <= '0;
            mask_q   <= '1;
`ifdef TOY_INTC_RR_EN
            lastId_q <= '0;
`endif
        end else begin
            if (maskWe) begin
                mask_q <= maskIn;
            end
            case (state_q)
                S_IDLE: begin
                    if (pend != '0) begin
                        state_q <= S_REQ;
                        irq_q   <= 1'b1;
                        irqId_q <= winner;
                    end
                end
                S_REQ: begin
                    // take beats a same-cycle withdrawal; eoi is ignored here.
                    if (take) begin
                        state_q  <= S_ACK;
                        irq_q    <= 1'b0;
                        ack_q    <= ackSel;
`ifdef TOY_INTC_RR_EN
                        lastId_q <= irqId_q;
`endif
                    end else if (!pendSel) begin
                        state_q <= S_IDLE;
                        irq_q   <= 1'b0;
                    end
                end
                S_ACK: begin
                    state_q <= S_SERVICE;
                    ack_q   <= '0;
                end
                S_SERVICE: begin
                    if (eoi) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack     = ack_q;
    assign maskOut = mask_q;
    assign irq     = irq_q;
    assign irqId   = irqId_q;
    assign busy    = (state_q == S_ACK) || (state_q == S_SERVICE);

endmodule
`default_nettype wire
